// File: rtl/kt8_dmem_io_pkg.sv
// KT8 data-space shared constants: I/O register offsets and STATUS bit positions.
package kt8_dmem_io_pkg;

  localparam int unsigned IO_GPIO_OUT  = 0;
  localparam int unsigned IO_GPIO_IN   = 1;
  localparam int unsigned IO_TIMER_CNT = 2;
  localparam int unsigned IO_TIMER_CMP = 3;
  localparam int unsigned IO_STATUS    = 4;
  localparam int unsigned IO_TX_DATA   = 5;
  localparam int unsigned IO_IRQ_EN    = 6;

  localparam int unsigned ST_MATCH = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;

endpackage

// File: rtl/kt8_dmem_io_if.sv
// KT8 CPU data port: address, write data, write strobe and combinational read data.
interface kt8_dmem_io_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] address_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              we_i;

  modport master (output address_i, output data_i, output we_i, input data_o);
  modport slave  (input address_i, input data_i, input we_i, output data_o);
endinterface

// File: rtl/kt8_dmem_io_fifo.sv
// TX output FIFO: write-side push with drop-on-full, valid/ready drain on the read side.
module kt8_dmem_io_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              full_c,
  output logic              empty_c,
  output logic              drop_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              valid_c,
  input  logic              ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop_c, accept_c;

  // Flags, handshake and pointer/count update; a pop frees the slot a full push needs.
  always_comb begin
    valid_c  = (count_q != '0);
    empty_c  = !valid_c;
    full_c   = (count_q == FULL_CNT);
    pop_c    = valid_c & ready_i;
    accept_c = push_i & (!full_c | pop_c);
    drop_c   = push_i & full_c & !pop_c;
    rdata_c  = mem_q[rd_ptr_q];
    wr_ptr_d = accept_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(accept_c) - CW'(pop_c);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the empty count hides stale entries.
  always_ff @(posedge clk_i) begin
    if (accept_c) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/kt8_dmem_io.sv
// KT8 data-space subsystem: RAM in the low half, GPIO/timer/TX FIFO registers in the high half.
module kt8_dmem_io
  import kt8_dmem_io_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned RAM_DEPTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GPIO_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  kt8_dmem_io_if.slave      bus,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              irq_o
);

  localparam int unsigned OFF_W  = ADDR_W - 1;
  localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(RAM_DEPTH);

  logic [DATA_W-1:0] ram_q [RAM_DEPTH];
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_s1_q, gpio_s2_q;
  logic [DATA_W-1:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic              match_q, match_d, ovf_q, ovf_d, irq_en_q, irq_en_d;

  logic              is_io, ram_hit, push_c;
  logic [OFF_W-1:0]  io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] status_c;
  logic              fifo_full, fifo_empty, fifo_drop;

  assign is_io   = bus.address_i[ADDR_W-1];
  assign io_off  = bus.address_i[OFF_W-1:0];
  assign ram_hit = !is_io && (bus.address_i < RAM_LIMIT);
  assign ram_idx = RAM_AW'(bus.address_i);
  assign push_c  = bus.we_i && is_io && (io_off == OFF_W'(IO_TX_DATA));

  kt8_dmem_io_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_c),
    .wdata_i (bus.data_i),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .drop_c  (fifo_drop),
    .rdata_c (tx_data_o),
    .valid_c (tx_valid_o),
    .ready_i (tx_ready_i)
  );

  // Register writes, free-running timer and sticky flags; a flag set beats a same-cycle W1C.
  always_comb begin
    gpio_out_d = gpio_out_q;
    cmp_d      = cmp_q;
    irq_en_d   = irq_en_q;
    match_d    = match_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q + DATA_W'(1);
    if (bus.we_i && is_io) begin
      case (io_off)
        OFF_W'(IO_GPIO_OUT):  gpio_out_d = bus.data_i[GPIO_W-1:0];
        OFF_W'(IO_TIMER_CMP): cmp_d      = bus.data_i;
        OFF_W'(IO_IRQ_EN):    irq_en_d   = bus.data_i[0];
        OFF_W'(IO_STATUS): begin
          if (bus.data_i[ST_MATCH]) match_d = 1'b0;
          if (bus.data_i[ST_OVF])   ovf_d   = 1'b0;
        end
        default: ;
      endcase
    end
    if (cnt_q == cmp_q) match_d = 1'b1;
    if (fifo_drop)      ovf_d   = 1'b1;
  end

  // Control/status registers and the two-stage GPIO input synchroniser.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
      cnt_q      <= '0;
      cmp_q      <= '0;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_s1_q  <= gpio_i;
      gpio_s2_q  <= gpio_s1_q;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
    end
  end

  // Data RAM is deliberately unreset so preloaded contents survive reset.
  always_ff @(posedge clk_i) begin
    if (bus.we_i && ram_hit) ram_q[ram_idx] <= bus.data_i;
  end

  // Combinational read mux; unmapped and write-only locations read zero.
  always_comb begin
    status_c           = '0;
    status_c[ST_MATCH] = match_q;
    status_c[ST_FULL]  = fifo_full;
    status_c[ST_EMPTY] = fifo_empty;
    status_c[ST_OVF]   = ovf_q;
    bus.data_o         = '0;
    if (!is_io) begin
      if (ram_hit) bus.data_o = ram_q[ram_idx];
    end else begin
      case (io_off)
        OFF_W'(IO_GPIO_OUT):  bus.data_o = DATA_W'(gpio_out_q);
        OFF_W'(IO_GPIO_IN):   bus.data_o = DATA_W'(gpio_s2_q);
        OFF_W'(IO_TIMER_CNT): bus.data_o = cnt_q;
        OFF_W'(IO_TIMER_CMP): bus.data_o = cmp_q;
        OFF_W'(IO_STATUS):    bus.data_o = status_c;
        OFF_W'(IO_IRQ_EN):    bus.data_o = DATA_W'(irq_en_q);
        default:              bus.data_o = '0;
      endcase
    end
  end

  assign gpio_o = gpio_out_q;
  assign irq_o  = match_q & irq_en_q;

endmodule
